// File: rtl/ffo_share_ctrl.sv
// Round-robin front end that shares one sequential find-first-one engine among
// several requesters, sequences its start/ready handshake and guards it with a watchdog.
module ffo_share_ctrl #(
    parameter int NREQ    = 4,
    parameter int N       = 32,
    parameter int TIMEOUT = 64,
    localparam int PW     = $clog2(N)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   ack,
    output logic              res_v,
    output logic [PW-1:0]     res_p,
    output logic              res_err,
    output logic              busy,
    output logic              eng_start,
    output logic [N-1:0]      eng_b,
    input  logic              eng_v,
    input  logic [PW-1:0]     eng_p,
    input  logic              eng_ready
);

    localparam int GW = $clog2(NREQ);
    localparam int WW = $clog2(TIMEOUT);

    // The comparison is against the pre-increment value, so the count reaches
    // TIMEOUT-1 on the very edge that leaves for DONE.
    localparam logic [WW-1:0]   WD_EXPIRE = WW'(TIMEOUT - 2);
    localparam logic [WW-1:0]   WD_STEP   = {{(WW-1){1'b0}}, 1'b1};
    localparam logic [GW-1:0]   LAST_RST  = GW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        DONE      = 3'd4
    } state_t;

    // Returns {found, index}; the smallest offset after last wins, so the
    // requester just served drops to lowest priority.
    function automatic logic [GW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [GW-1:0]   last);
        logic [GW:0]   pick;
        logic [GW-1:0] k;
        pick = {(GW+1){1'b0}};
        for (int i = NREQ; i >= 1; i--) begin
            k    = GW'((int'(last) + i) % NREQ);
            pick = r[k] ? {1'b1, k} : pick;
        end
        return pick;
    endfunction

    state_t          state_r;
    state_t          state_s;
    logic [GW-1:0]   last_r;
    logic [GW-1:0]   last_s;
    logic [GW-1:0]   grant_r;
    logic [GW-1:0]   grant_s;
    logic [WW-1:0]   wd_cnt_r;
    logic [WW-1:0]   wd_cnt_s;
    logic [GW:0]     pick_s;
    logic            expired_s;
    logic [N-1:0]    eng_b_s;
    logic            start_s;
    logic [NREQ-1:0] ack_s;
    logic            res_v_s;
    logic [PW-1:0]   res_p_s;
    logic            res_err_s;

    assign pick_s    = rr_pick(req, last_r);
    assign expired_s = (wd_cnt_r == WD_EXPIRE);

    // Next-state and next-output decode; every output is registered from these.
    always_comb begin
        state_s   = state_r;
        last_s    = last_r;
        grant_s   = grant_r;
        wd_cnt_s  = wd_cnt_r;
        eng_b_s   = eng_b;
        start_s   = 1'b0;
        ack_s     = {NREQ{1'b0}};
        res_v_s   = 1'b0;
        res_p_s   = {PW{1'b0}};
        res_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_s[GW]) begin
                    state_s = LAUNCH;
                    grant_s = pick_s[GW-1:0];
                    eng_b_s = req_b[int'(pick_s[GW-1:0]) * N +: N];
                    start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            LAUNCH: begin
                wd_cnt_s = {WW{1'b0}};
                state_s  = WAIT_LOW;
            end
            WAIT_LOW: begin
                wd_cnt_s = wd_cnt_r + WD_STEP;
                if (!eng_ready) begin
                    state_s = WAIT_HIGH;
                end else if (expired_s) begin
                    state_s   = DONE;
                    ack_s     = ONE_HOT0 << grant_r;
                    res_err_s = 1'b1;
                end else begin
                    state_s = WAIT_LOW;
                end
            end
            WAIT_HIGH: begin
                wd_cnt_s = wd_cnt_r + WD_STEP;
                // A completion on the expiry edge still counts as a normal result.
                if (eng_ready) begin
                    state_s = DONE;
                    ack_s   = ONE_HOT0 << grant_r;
                    res_v_s = eng_v;
                    res_p_s = eng_v ? eng_p : {PW{1'b0}};
                end else if (expired_s) begin
                    state_s   = DONE;
                    ack_s     = ONE_HOT0 << grant_r;
                    res_err_s = 1'b1;
                end else begin
                    state_s = WAIT_HIGH;
                end
            end
            DONE: begin
                last_s  = grant_r;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, arbitration pointer, watchdog and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            last_r    <= LAST_RST;
            grant_r   <= {GW{1'b0}};
            wd_cnt_r  <= {WW{1'b0}};
            eng_b     <= {N{1'b0}};
            eng_start <= 1'b0;
            ack       <= {NREQ{1'b0}};
            res_v     <= 1'b0;
            res_p     <= {PW{1'b0}};
            res_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_s;
            last_r    <= last_s;
            grant_r   <= grant_s;
            wd_cnt_r  <= wd_cnt_s;
            eng_b     <= eng_b_s;
            eng_start <= start_s;
            ack       <= ack_s;
            res_v     <= res_v_s;
            res_p     <= res_p_s;
            res_err   <= res_err_s;
            busy      <= (state_s != IDLE);
        end
    end

endmodule

// File: tb/tb_ffo_share_ctrl.sv
// Directed bench for ffo_share_ctrl: a behavioural engine with settable latency or
// stuck ready, scenario tasks with inline hand-computed expectations.
module tb_ffo_share_ctrl;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req   = 4'b0000;
    logic [127:0] req_b = 128'd0;
    logic [3:0]   ack;
    logic         res_v;
    logic [4:0]   res_p;
    logic         res_err;
    logic         busy;
    logic         eng_start;
    logic [31:0]  eng_b;
    logic         eng_v = 1'b0;
    logic [4:0]   eng_p = 5'd0;
    logic         eng_ready;

    int   errors    = 0;
    int   checks    = 0;
    int   eng_lat   = 3;
    int   eng_mode  = 0;
    logic eng_rdy_m = 1'b1;
    int   eng_cnt   = 0;

    ffo_share_ctrl #(.NREQ(4), .N(32), .TIMEOUT(64)) dut (
        .clock(clock), .reset(reset), .req(req), .req_b(req_b), .ack(ack),
        .res_v(res_v), .res_p(res_p), .res_err(res_err), .busy(busy),
        .eng_start(eng_start), .eng_b(eng_b), .eng_v(eng_v), .eng_p(eng_p),
        .eng_ready(eng_ready)
    );

    always #5 clock = ~clock;

    // Engine reports an all-ones position for a zero word so forcing to 0 is visible.
    function automatic logic [4:0] ffo(input logic [31:0] b);
        logic [4:0] p;
        p = 5'h1F;
        for (int i = 31; i >= 0; i--) if (b[i]) p = 5'(i);
        return p;
    endfunction

    // Engine: ready drops on the edge that samples start, rises eng_lat+1 edges later.
    always @(posedge clock) begin
        if (eng_start) begin
            eng_rdy_m <= 1'b0;
            eng_cnt   <= eng_lat;
            eng_v     <= |eng_b;
            eng_p     <= ffo(eng_b);
        end else if (!eng_rdy_m) begin
            if (eng_cnt == 0) eng_rdy_m <= 1'b1;
            else              eng_cnt   <= eng_cnt - 1;
        end
    end

    assign eng_ready = (eng_mode == 1) ? 1'b1 : ((eng_mode == 2) ? 1'b0 : eng_rdy_m);

    task automatic set_word(input int k, input logic [31:0] w);
        req_b[k*32 +: 32] = w;
    endtask

    task automatic wait_ack(input int budget, output int cyc);
        @(negedge clock);
        cyc = 1;
        while (ack == 4'b0000 && cyc < budget) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic wait_start(input int budget);
        int c;
        @(negedge clock);
        c = 1;
        while (!eng_start && c < budget) begin
            @(negedge clock);
            c++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (ack !== 4'b0000)  begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        checks++; if (res_v !== 1'b0)   begin errors++; $display("FAIL reset_res_v: got %b expected 0", res_v); end
        checks++; if (res_p !== 5'd0)   begin errors++; $display("FAIL reset_res_p: got %0d expected 0", res_p); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL reset_res_err: got %b expected 0", res_err); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", eng_start); end
        checks++; if (eng_b !== 32'd0)  begin errors++; $display("FAIL reset_eng_b: got %h expected 0", eng_b); end
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_single();
        int starts;
        int ack_c;
        starts  = 0;
        ack_c   = 0;
        eng_lat = 10;
        set_word(0, 32'h0000_0060);
        req = 4'b0001;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (eng_start) starts++;
            if (c == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
                checks++; if (res_v !== 1'b0) begin errors++; $display("FAIL single_res_idle: got %b expected 0", res_v); end
            end
            if (ack !== 4'b0000) begin
                ack_c = c;
                break;
            end
        end
        checks++; if (starts != 1)      begin errors++; $display("FAIL single_start_width: got %0d expected 1", starts); end
        checks++; if (ack_c != 14)      begin errors++; $display("FAIL single_latency: got %0d expected 14", ack_c); end
        checks++; if (ack !== 4'b0001)  begin errors++; $display("FAIL single_ack: got %b expected 0001", ack); end
        checks++; if (res_v !== 1'b1)   begin errors++; $display("FAIL single_res_v: got %b expected 1", res_v); end
        checks++; if (res_p !== 5'd5)   begin errors++; $display("FAIL single_res_p: got %0d expected 5", res_p); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL single_res_err: got %b expected 0", res_err); end
        req = 4'b0000;
        @(negedge clock);
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_pulse: got %b expected 0000", ack); end
        checks++; if (res_p !== 5'd0)  begin errors++; $display("FAIL single_res_p_clear: got %0d expected 0", res_p); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL single_busy_done: got %b expected 0", busy); end
        checks++; if (eng_b !== 32'h0000_0060) begin errors++; $display("FAIL single_eng_b_hold: got %h expected 00000060", eng_b); end
    endtask

    task automatic test_zero();
        int cyc;
        eng_lat = 3;
        set_word(2, 32'h0000_0000);
        req = 4'b0100;
        wait_ack(60, cyc);
        checks++; if (ack !== 4'b0100)  begin errors++; $display("FAIL zero_ack: got %b expected 0100", ack); end
        checks++; if (res_v !== 1'b0)   begin errors++; $display("FAIL zero_res_v: got %b expected 0", res_v); end
        checks++; if (res_p !== 5'd0)   begin errors++; $display("FAIL zero_res_p: got %0d expected 0", res_p); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL zero_res_err: got %b expected 0", res_err); end
        req = 4'b0000;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_fairness();
        logic [3:0] exp_ack [4];
        logic [4:0] exp_p [4];
        int cyc;
        exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_p   = '{5'd3, 5'd8, 5'd31, 5'd10};
        eng_lat = 3;
        reset = 1'b1;
        set_word(0, 32'h0000_0008);
        set_word(1, 32'h0001_0100);
        set_word(2, 32'h8000_0000);
        set_word(3, 32'h0000_0C00);
        req = 4'b1111;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_ack(60, cyc);
            checks++; if (ack !== exp_ack[i]) begin errors++; $display("FAIL fair_ack%0d: got %b expected %b", i, ack, exp_ack[i]); end
            checks++; if (res_p !== exp_p[i]) begin errors++; $display("FAIL fair_res_p%0d: got %0d expected %0d", i, res_p, exp_p[i]); end
            checks++; if (res_v !== 1'b1)     begin errors++; $display("FAIL fair_res_v%0d: got %b expected 1", i, res_v); end
            req = req & ~exp_ack[i];
            if (i == 0) begin
                @(negedge clock);
                checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL fair_idle_gap: got busy %b expected 0", busy); end
                @(negedge clock);
                checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL fair_next_launch: got %b expected 1", eng_start); end
            end
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_round_robin();
        int cyc;
        eng_lat = 2;
        set_word(1, 32'h0000_0004);
        req = 4'b0010;
        wait_ack(60, cyc);
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL rr_first_ack: got %b expected 0010", ack); end
        checks++; if (res_p !== 5'd2)  begin errors++; $display("FAIL rr_first_p: got %0d expected 2", res_p); end
        req = 4'b0000;
        repeat (2) @(negedge clock);
        req = 4'b0101;
        wait_ack(60, cyc);
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL rr_ack_2: got %b expected 0100", ack); end
        checks++; if (res_p !== 5'd31) begin errors++; $display("FAIL rr_p_2: got %0d expected 31", res_p); end
        req[2] = 1'b0;
        wait_ack(60, cyc);
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL rr_ack_0: got %b expected 0001", ack); end
        checks++; if (res_p !== 5'd3)  begin errors++; $display("FAIL rr_p_0: got %0d expected 3", res_p); end
        req[0] = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_watchdog();
        int cyc;
        eng_lat  = 2;
        eng_mode = 1;
        req = 4'b0010;
        wait_start(20);
        wait_ack(200, cyc);
        checks++; if (cyc != 64)        begin errors++; $display("FAIL wd_high_cycles: got %0d expected 64", cyc); end
        checks++; if (ack !== 4'b0010)  begin errors++; $display("FAIL wd_high_ack: got %b expected 0010", ack); end
        checks++; if (res_err !== 1'b1) begin errors++; $display("FAIL wd_high_err: got %b expected 1", res_err); end
        checks++; if (res_v !== 1'b0)   begin errors++; $display("FAIL wd_high_v: got %b expected 0", res_v); end
        checks++; if (res_p !== 5'd0)   begin errors++; $display("FAIL wd_high_p: got %0d expected 0", res_p); end
        req = 4'b0000;
        eng_mode = 0;
        repeat (2) @(negedge clock);
        req = 4'b0100;
        wait_ack(60, cyc);
        checks++; if (ack !== 4'b0100)  begin errors++; $display("FAIL wd_after_ack: got %b expected 0100", ack); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL wd_after_err: got %b expected 0", res_err); end
        checks++; if (res_p !== 5'd31)  begin errors++; $display("FAIL wd_after_p: got %0d expected 31", res_p); end
        req = 4'b0000;
        repeat (2) @(negedge clock);
        eng_mode = 2;
        req = 4'b1000;
        wait_start(20);
        wait_ack(200, cyc);
        checks++; if (cyc != 64)        begin errors++; $display("FAIL wd_low_cycles: got %0d expected 64", cyc); end
        checks++; if (ack !== 4'b1000)  begin errors++; $display("FAIL wd_low_ack: got %b expected 1000", ack); end
        checks++; if (res_err !== 1'b1) begin errors++; $display("FAIL wd_low_err: got %b expected 1", res_err); end
        req = 4'b0000;
        eng_mode = 0;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_simultaneous();
        int cyc;
        eng_lat = 61;
        req = 4'b1000;
        wait_start(20);
        wait_ack(200, cyc);
        checks++; if (cyc != 64)        begin errors++; $display("FAIL tie_cycles: got %0d expected 64", cyc); end
        checks++; if (ack !== 4'b1000)  begin errors++; $display("FAIL tie_ack: got %b expected 1000", ack); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL tie_err: got %b expected 0", res_err); end
        checks++; if (res_v !== 1'b1)   begin errors++; $display("FAIL tie_v: got %b expected 1", res_v); end
        checks++; if (res_p !== 5'd10)  begin errors++; $display("FAIL tie_p: got %0d expected 10", res_p); end
        req = 4'b0000;
        repeat (2) @(negedge clock);
        eng_lat = 62;
        req = 4'b0001;
        wait_start(20);
        wait_ack(200, cyc);
        checks++; if (cyc != 64)        begin errors++; $display("FAIL late_cycles: got %0d expected 64", cyc); end
        checks++; if (res_err !== 1'b1) begin errors++; $display("FAIL late_err: got %b expected 1", res_err); end
        checks++; if (res_v !== 1'b0)   begin errors++; $display("FAIL late_v: got %b expected 0", res_v); end
        req = 4'b0000;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int cyc;
        eng_lat = 20;
        req = 4'b0001;
        wait_start(20);
        repeat (5) @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        reset = 1'b1;
        req   = 4'b1001;
        @(negedge clock);
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (ack !== 4'b0000)    begin errors++; $display("FAIL mid_ack: got %b expected 0000", ack); end
        checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL mid_start: got %b expected 0", eng_start); end
        checks++; if (eng_b !== 32'd0)    begin errors++; $display("FAIL mid_eng_b: got %h expected 0", eng_b); end
        reset = 1'b0;
        wait_ack(60, cyc);
        checks++; if (cyc != 24)        begin errors++; $display("FAIL mid_reack_cycles: got %0d expected 24", cyc); end
        checks++; if (ack !== 4'b0001)  begin errors++; $display("FAIL mid_reack: got %b expected 0001", ack); end
        checks++; if (res_p !== 5'd3)   begin errors++; $display("FAIL mid_reack_p: got %0d expected 3", res_p); end
        req[0] = 1'b0;
        wait_ack(60, cyc);
        checks++; if (ack !== 4'b1000)  begin errors++; $display("FAIL mid_next_ack: got %b expected 1000", ack); end
        checks++; if (res_p !== 5'd10)  begin errors++; $display("FAIL mid_next_p: got %0d expected 10", res_p); end
        req = 4'b0000;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero();
        test_fairness();
        test_round_robin();
        test_watchdog();
        test_simultaneous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "simulation time limit reached");
    end

endmodule
